fft16_stage_sequencer: RTL and testbench
========================================

// Module: fft16_stage_sequencer
// PURPOSE
//  Control and storage stage that feeds the 8-butterfly array of the 16-point radix-2 FFT and collects its results.
//  Accepts 16 complex samples serially and stores them in bit-reversed order.
//  Runs 4 in-place DIT stages, presenting 8 operand pairs plus twiddles per cycle to the butterfly array.
//  Streams the 16 natural-order results out through a valid/ready handshake.
// PARAMETERS
//  DW      16  sample/twiddle width, two's complement; twiddles Q2.14 (1.0 = 16'h4000)
//  NPTS    16  transform size; fixed, other values are illegal (elaboration error)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      input sample valid
//  in_ready     out  1      block can accept a sample
//  in_re/in_im  in   DW     input sample
//  out_valid    out  1      result sample valid
//  out_ready    in   1      downstream accepts result
//  out_re/out_im out DW     result sample, natural order X[0..15]
//  bf_a_re/im   out  8xDW   butterfly operand 1 (top), lane b = 0..7
//  bf_b_re/im   out  8xDW   butterfly operand 2 (bottom)
//  bf_w_re/im   out  8xDW   twiddle per lane
//  bf_y1_re/im  in   8xDW   butterfly result top    (a + W*b), combinational return
//  bf_y2_re/im  in   8xDW   butterfly result bottom (a - W*b)
//  done         out  1      1-cycle pulse when stage 3 writes back
// BEHAVIOUR
//  Reset: state=LOAD, counters=0, in_ready=1, out_valid=0, done=0, out_re/out_im=0, bf_* outputs=0; memory contents are don't-care.
//  Storage: mem[16] of {re,im}; only this block writes it.
//  LOAD: in_ready=1. A transfer happens on in_valid&in_ready and writes mem[bitrev4(cnt)].
//    cnt increments per transfer. The transfer at cnt==15 moves state to COMP with stg=0 and cnt=0.
//  COMP: in_ready=0, out_valid=0. One cycle per stage, stg = 0..3.
//    span = 2^stg. Lane b: grp = b>>stg, j = b & (span-1).
//    top = grp*2*span + j, bot = top + span, twiddle index k = j << (3-stg), W = W16^k.
//    bf_a = mem[top], bf_b = mem[bot], bf_w = ROM[k]. All are combinational from mem and stg.
//    At the clock edge, mem[top] <= y1 and mem[bot] <= y2 for all 8 lanes simultaneously.
//    When stg==3 the edge pulses done and moves state to UNLD with cnt=0.
//  bf_* outputs are driven (not zeroed) in every state; they are meaningful only in COMP.
//  UNLD: out_valid=1; out_re/im = mem[cnt] (registered, updated on transfer).
//    A transfer on out_valid&out_ready increments cnt; the transfer at cnt==15 returns to LOAD.
//    While out_ready=0, out_* are held stable.
//  Latency: last input accept to first out_valid = 5 cycles (4 COMP + 1 output register).
//  Boundaries:
//    - in_valid outside LOAD is ignored (in_ready=0).
//    - rst asserted in any state aborts the frame; next cycle is LOAD, cnt=0.
//    - No overlap between frames: a new LOAD starts only after the 16th output transfer.
//  Arithmetic: write-back truncates y1/y2 to DW; overflow wraps; no saturation in this block.
// CONFIGURATION
//  FFT16_STAGE_SCALE_EN defined: write-back stores y>>>1 (arithmetic), giving 1/16 total scaling.
//  FFT16_STAGE_SCALE_EN undefined: write-back stores y unchanged.
// STRUCTURE
//  Package fft16_pkg:
//    - cplx_t struct {re, im}
//    - state_t enum {LOAD, COMP, UNLD}
//    - twiddle ROM constant TW_RE/TW_IM[8] for W16^0..7 in Q2.14
//    - bitrev4() function
//  Sub-module fft16_stage_addr_gen: combinational stg -> top/bot/k for the 8 lanes.
//  Everything else lives in this module.
// TESTING (bench instantiates the 8-butterfly array model on bf_* ports)
//  1. Impulse: x[0]=0x0100, rest 0 -> all 16 outputs re=0x0100, im=0.
//     With FFT16_STAGE_SCALE_EN defined -> all outputs re=0x0010.
//  2. DC: all x=0x0100 -> X[0].re=0x1000, all other X=0.
//     With FFT16_STAGE_SCALE_EN defined -> X[0].re=0x0100.
//  3. Backpressure: hold out_ready=0 for 10 cycles at cnt=3 -> out_valid stays 1 and out_re/out_im hold X[3].
//     No sample is lost or duplicated.
//  4. in_valid held high through COMP/UNLD -> in_ready=0 and no mem change.
//     Next frame loads correctly after the 16th output.
//  5. Reset mid-COMP (stg=2) -> next cycle LOAD, in_ready=1, out_valid=0, done never pulses.
//     A fresh impulse frame then gives the step 1 result.
//  6. Check done is a single-cycle pulse exactly 4 cycles after the 16th input accept.

Source files
------------

// File: rtl/fft16_pkg.sv
// Shared types, constants and helpers for the 16-point radix-2 FFT stage sequencer.
package fft16_pkg;

  localparam int DW    = 16;
  localparam int NPTS  = 16;
  localparam int NLANE = 8;

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    COMP = 2'd1,
    UNLD = 2'd2
  } state_t;

  // W16^k = exp(-j*2*pi*k/16) for k = 0..7, Q2.14 (1.0 = 16'h4000)
  localparam logic [DW-1:0] TW_RE [NLANE] = '{
    16'h4000, 16'h3B21, 16'h2D41, 16'h187E,
    16'h0000, 16'hE782, 16'hD2BF, 16'hC4DF
  };
  localparam logic [DW-1:0] TW_IM [NLANE] = '{
    16'h0000, 16'hE782, 16'hD2BF, 16'hC4DF,
    16'hC000, 16'hC4DF, 16'hD2BF, 16'hE782
  };

  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

// File: rtl/fft16_stage_addr_gen.sv
// Per-lane in-place DIT addressing: stage index -> top/bottom memory index and twiddle index.
module fft16_stage_addr_gen
  import fft16_pkg::*;
(
  input  logic [1:0]         stg,
  output logic [4*NLANE-1:0] top_idx,
  output logic [4*NLANE-1:0] bot_idx,
  output logic [3*NLANE-1:0] tw_idx
);

  // Position of a lane within its butterfly group: j = lane & (span-1)
  function automatic logic [3:0] lane_j(input logic [2:0] lane, input logic [1:0] s);
    logic [3:0] span_m1;
    span_m1 = (4'd1 << s) - 4'd1;
    return {1'b0, lane} & span_m1;
  endfunction

  // Address/twiddle decode for all eight lanes of the current stage
  always_comb begin
    // NOTE: every output gets a default before the loop so no path can infer a latch.
    top_idx = '0;
    bot_idx = '0;
    tw_idx  = '0;
    for (int l = 0; l < NLANE; l++) begin
      top_idx[4*l +: 4] = ((({1'b0, 3'(l)} >> stg) << ({1'b0, stg} + 3'd1)))
                          | lane_j(3'(l), stg);
      bot_idx[4*l +: 4] = top_idx[4*l +: 4] + (4'd1 << stg);
      tw_idx[3*l +: 3]  = 3'(lane_j(3'(l), stg) << (2'd3 - stg));
    end
  end

endmodule

// File: rtl/fft16_stage_sequencer.sv
// Control and storage for a 16-point radix-2 DIT FFT built around an external 8-butterfly array.
// Optional feature: define FFT16_STAGE_SCALE_EN to halve every write-back (1/16 total scaling).
module fft16_stage_sequencer
  import fft16_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NPTS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_re,
  input  logic [DW-1:0]      in_im,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_re,
  output logic [DW-1:0]      out_im,
  output logic [8*DW-1:0]    bf_a_re,
  output logic [8*DW-1:0]    bf_a_im,
  output logic [8*DW-1:0]    bf_b_re,
  output logic [8*DW-1:0]    bf_b_im,
  output logic [8*DW-1:0]    bf_w_re,
  output logic [8*DW-1:0]    bf_w_im,
  input  logic [8*DW-1:0]    bf_y1_re,
  input  logic [8*DW-1:0]    bf_y1_im,
  input  logic [8*DW-1:0]    bf_y2_re,
  input  logic [8*DW-1:0]    bf_y2_im,
  output logic               done
);

  if (NPTS != 16 || DW != fft16_pkg::DW) begin : g_bad_cfg
    $error("fft16_stage_sequencer supports only NPTS=16 and DW=16");
  end

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic [1:0]         stg;
  cplx_t              mem [NPTS];
  logic [4*NLANE-1:0] top_idx, bot_idx;
  logic [3*NLANE-1:0] tw_idx;
  logic               in_fire;

  fft16_stage_addr_gen u_addr_gen (
    .stg     (stg),
    .top_idx (top_idx),
    .bot_idx (bot_idx),
    .tw_idx  (tw_idx)
  );

  assign in_ready = (state == LOAD);
  assign in_fire  = in_valid & in_ready;

  // Butterfly result as stored back into memory
  function automatic logic [DW-1:0] wb(input logic [DW-1:0] y);
`ifdef FFT16_STAGE_SCALE_EN
    return $signed(y) >>> 1;
`else
    return y;
`endif
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && cnt == 4'd15) state_nxt = COMP;
      COMP:    if (stg == 2'd3) state_nxt = UNLD;
      UNLD:    if (out_valid && out_ready && cnt == 4'd15) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Counters, stage index, registered output sample and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      stg       <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          stg <= '0;
          if (in_fire) cnt <= cnt + 4'd1;
        end
        COMP: begin
          cnt <= '0;
          stg <= stg + 2'd1;
          if (stg == 2'd3) done <= 1'b1;
        end
        UNLD: begin
          if (!out_valid) begin
            // First UNLD cycle primes the output register once stage 3 has landed.
            out_re    <= mem[cnt].re;
            out_im    <= mem[cnt].im;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              out_valid <= 1'b0;
            end else begin
              out_re <= mem[cnt + 4'd1].re;
              out_im <= mem[cnt + 4'd1].im;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Sample store: bit-reversed serial load, then in-place write-back of all 8 butterflies
  // NOTE: the sample memory is deliberately not reset; every frame overwrites all 16 entries before use.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[bitrev4(cnt)] <= '{re: in_re, im: in_im};
    end else if (state == COMP) begin
      for (int l = 0; l < NLANE; l++) begin
        mem[top_idx[4*l +: 4]] <= '{re: wb(bf_y1_re[DW*l +: DW]), im: wb(bf_y1_im[DW*l +: DW])};
        mem[bot_idx[4*l +: 4]] <= '{re: wb(bf_y2_re[DW*l +: DW]), im: wb(bf_y2_im[DW*l +: DW])};
      end
    end
  end

  // Operand and twiddle fan-out to the butterfly array, held at zero during reset
  always_comb begin
    bf_a_re = '0;
    bf_a_im = '0;
    bf_b_re = '0;
    bf_b_im = '0;
    bf_w_re = '0;
    bf_w_im = '0;
    if (!rst) begin
      for (int l = 0; l < NLANE; l++) begin
        bf_a_re[DW*l +: DW] = mem[top_idx[4*l +: 4]].re;
        bf_a_im[DW*l +: DW] = mem[top_idx[4*l +: 4]].im;
        bf_b_re[DW*l +: DW] = mem[bot_idx[4*l +: 4]].re;
        bf_b_im[DW*l +: DW] = mem[bot_idx[4*l +: 4]].im;
        bf_w_re[DW*l +: DW] = TW_RE[tw_idx[3*l +: 3]];
        bf_w_im[DW*l +: DW] = TW_IM[tw_idx[3*l +: 3]];
      end
    end
  end

endmodule

// File: tb/tb_fft16_stage_sequencer.sv
// Self-checking bench for fft16_stage_sequencer with a fixed-point butterfly array model.
module tb_fft16_stage_sequencer;

  localparam int DW = 16;
`ifdef FFT16_STAGE_SCALE_EN
  localparam bit SCALE = 1'b1;
`else
  localparam bit SCALE = 1'b0;
`endif
  localparam int IMP_OUT = SCALE ? 16 : 256;
  localparam int DC_OUT  = SCALE ? 256 : 4096;

  typedef int frame_t [16];
  typedef struct {
    int re;
    int im;
    int tol;
  } exp_t;

  logic clk, rst, in_valid, in_ready, out_valid, out_ready, done;
  logic [DW-1:0]   in_re, in_im, out_re, out_im;
  logic [8*DW-1:0] bf_a_re, bf_a_im, bf_b_re, bf_b_im, bf_w_re, bf_w_im;
  logic [8*DW-1:0] bf_y1_re, bf_y1_im, bf_y2_re, bf_y2_im;
  logic [63:0]     bf_tmp;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  fft16_stage_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .bf_a_re(bf_a_re), .bf_a_im(bf_a_im), .bf_b_re(bf_b_re), .bf_b_im(bf_b_im),
    .bf_w_re(bf_w_re), .bf_w_im(bf_w_im),
    .bf_y1_re(bf_y1_re), .bf_y1_im(bf_y1_im), .bf_y2_re(bf_y2_re), .bf_y2_im(bf_y2_im),
    .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  // Butterfly: y1 = a + W*b, y2 = a - W*b, W in Q2.14, results wrapped to 16 bits
  function automatic logic [63:0] bfly(input logic [15:0] ar, ai, br, bi, wr, wi);
    int pr, pim, r1, i1, r2, i2;
    pr  = (int'($signed(wr)) * int'($signed(br)) - int'($signed(wi)) * int'($signed(bi))) >>> 14;
    pim = (int'($signed(wr)) * int'($signed(bi)) + int'($signed(wi)) * int'($signed(br))) >>> 14;
    r1 = int'($signed(ar)) + pr;
    i1 = int'($signed(ai)) + pim;
    r2 = int'($signed(ar)) - pr;
    i2 = int'($signed(ai)) - pim;
    return {r1[15:0], i1[15:0], r2[15:0], i2[15:0]};
  endfunction

  always_comb begin
    bf_y1_re = '0;
    bf_y1_im = '0;
    bf_y2_re = '0;
    bf_y2_im = '0;
    bf_tmp   = '0;
    for (int l = 0; l < 8; l++) begin
      bf_tmp = bfly(bf_a_re[16*l +: 16], bf_a_im[16*l +: 16], bf_b_re[16*l +: 16],
                    bf_b_im[16*l +: 16], bf_w_re[16*l +: 16], bf_w_im[16*l +: 16]);
      bf_y1_re[16*l +: 16] = bf_tmp[63:48];
      bf_y1_im[16*l +: 16] = bf_tmp[47:32];
      bf_y2_re[16*l +: 16] = bf_tmp[31:16];
      bf_y2_im[16*l +: 16] = bf_tmp[15:0];
    end
  end

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int expv, input int tol);
    logic ok;
    ok = ((obs - expv) <= tol) && ((expv - obs) <= tol);
    n_assert++;
    assert (ok === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (+/-%0d)", tag, obs, expv, tol);
    end
  endtask

  task automatic cmp_sample(input string tag, input exp_t e);
    if (e.tol == 0) begin
      check({tag, "_re"}, sext(out_re), e.re);
      check({tag, "_im"}, sext(out_im), e.im);
    end else begin
      check_near({tag, "_re"}, int'($signed(out_re)), e.re, e.tol);
      check_near({tag, "_im"}, int'($signed(out_im)), e.im, e.tol);
    end
  endtask

  task automatic push(input int re, input int im, input int tol);
    exp_t e;
    e.re = re; e.im = im; e.tol = tol;
    sb.push_back(e);
  endtask

  // mode 0: plain load; 1: check latency/done/in_ready; 2: reset while stg==2
  task automatic load_frame(input frame_t xr, input frame_t xi, input int mode, input bit keep_valid);
    int w;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_re    = 16'(xr[i]);
      in_im    = 16'(xi[i]);
      w = 0;
      while (in_ready !== 1'b1 && w < 64) begin
        @(negedge clk);
        w++;
      end
      if (w >= 64) begin
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        break;
      end
      @(posedge clk);
    end
    #1;
    if (keep_valid) begin
      in_re = 16'h7777;
      in_im = 16'h8888;
    end else begin
      in_valid = 1'b0;
    end
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mode == 1) begin
        check($sformatf("done_c%0d", c), {31'b0, done}, {31'b0, c == 5});
        check($sformatf("out_valid_c%0d", c), {31'b0, out_valid}, {31'b0, c == 6});
        check($sformatf("in_ready_c%0d", c), {31'b0, in_ready}, 32'd0);
      end else if (mode == 2) begin
        if (c == 3) begin
          rst = 1'b1;
        end else if (c == 4) begin
          check("abort_in_ready", {31'b0, in_ready}, 32'd1);
          check("abort_out_valid", {31'b0, out_valid}, 32'd0);
          check("abort_done", {31'b0, done}, 32'd0);
          rst = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic drain(input int stall_at, input int stall_len);
    int   got, guard, stalled;
    exp_t e;
    got = 0; guard = 0; stalled = 0;
    while (got < 16 && guard < 400) begin
      @(negedge clk);
      guard++;
      if (got == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        check($sformatf("bp_valid_%0d", stalled), {31'b0, out_valid}, 32'd1);
        if (sb.size() > 0) cmp_sample($sformatf("bp_hold_%0d", stalled), sb[0]);
      end else begin
        out_ready = 1'b1;
        if (out_valid === 1'b1) begin
          if (sb.size() == 0) begin
            check("sb_underflow", sb.size(), 32'd1);
          end else begin
            e = sb.pop_front();
            cmp_sample($sformatf("X%0d", got), e);
          end
          got++;
        end
      end
    end
    check("drain_count", got, 32'd16);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    check("post_out_valid", {31'b0, out_valid}, 32'd0);
    check("post_in_ready", {31'b0, in_ready}, 32'd1);
    check("sb_empty", sb.size(), 32'd0);
  endtask

  task automatic push_dft(input frame_t xr, input frame_t xi);
    real ang, sr, si;
    for (int k = 0; k < 16; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 16; n++) begin
        ang = -2.0 * 3.14159265358979 * real'(n * k) / 16.0;
        sr += real'(xr[n]) * $cos(ang) - real'(xi[n]) * $sin(ang);
        si += real'(xr[n]) * $sin(ang) + real'(xi[n]) * $cos(ang);
      end
      if (SCALE) begin
        sr = sr / 16.0;
        si = si / 16.0;
      end
      push(int'(sr), int'(si), 12);
    end
  endtask

  initial begin
    frame_t imp_r, dc_r, zero_f, rnd_r, rnd_i;
    int     done_snap;
    for (int i = 0; i < 16; i++) begin
      imp_r[i]  = (i == 0) ? 256 : 0;
      dc_r[i]   = 256;
      zero_f[i] = 0;
      rnd_r[i]  = int'($urandom_range(2000)) - 1000;
      rnd_i[i]  = int'($urandom_range(2000)) - 1000;
    end

    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_out_re", sext(out_re), 32'd0);
    check("rst_out_im", sext(out_im), 32'd0);
    check("rst_bf_a_re", bf_a_re[31:0], 32'd0);
    check("rst_bf_w_re", bf_w_re[31:0], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("load_w0_re", {16'd0, bf_w_re[15:0]}, 32'h4000);

    // Impulse with latency and done-pulse checks
    for (int i = 0; i < 16; i++) push(IMP_OUT, 0, 0);
    load_frame(imp_r, zero_f, 1, 1'b0);
    drain(-1, 0);

    // DC
    push(DC_OUT, 0, 0);
    for (int i = 1; i < 16; i++) push(0, 0, 0);
    load_frame(dc_r, zero_f, 0, 1'b0);
    drain(-1, 0);

    // Impulse with in_valid held high (garbage data) through COMP and UNLD
    for (int i = 0; i < 16; i++) push(IMP_OUT, 0, 0);
    load_frame(imp_r, zero_f, 1, 1'b1);
    drain(-1, 0);

    // Random frame against a floating-point DFT, with 10-cycle backpressure at X[3]
    push_dft(rnd_r, rnd_i);
    load_frame(rnd_r, rnd_i, 0, 1'b0);
    drain(3, 10);

    // Reset during stage 2: frame discarded, done must not pulse
    done_snap = done_cnt;
    load_frame(dc_r, zero_f, 2, 1'b0);
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt, done_snap);
    check("abort_idle_out_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 16; i++) push(IMP_OUT, 0, 0);
    load_frame(imp_r, zero_f, 0, 1'b0);
    drain(-1, 0);
    check("done_total", done_cnt, done_snap + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
